// File: rtl/circle_op_issuer.sv
// circle_op_issuer
//   Command-side transmitter for circle_drawing_engine. Takes circle draw
//   requests as separate fields and silently drops degenerate or off-screen
//   ones. It packs the rest into the engine's 42-bit op word
//   {x, y, r, color}, queues them in a small FIFO, and issues them over an
//   rts/rtr handshake.
//
// Ports
//   clk        : clock, rising edge
//   rst_       : asynchronous reset, active-high
//   in_x/in_y  : circle centre (10 bits each)
//   in_r       : radius (10 bits)
//   in_color   : pixel colour (12 bits)
//   in_rts     : upstream request valid
//   in_rtr     : block can take a request (!full, low during reset)
//   out_op     : head op word, 0 when the queue is empty
//   out_rts    : op valid toward the engine (!empty)
//   out_rtr    : engine ready
//   level      : queued op count, 0..DEPTH
//   issued_cnt : ops handed to the engine, wraps mod 2^16
//   drop_cnt   : rejected requests, saturates at 255
module circle_op_issuer #(
  parameter int DEPTH    = 4,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic                       clk,
  input  logic                       rst_,
  input  logic [9:0]                 in_x,
  input  logic [9:0]                 in_y,
  input  logic [9:0]                 in_r,
  input  logic [11:0]                in_color,
  input  logic                       in_rts,
  output logic                       in_rtr,
  output logic [41:0]                out_op,
  output logic                       out_rts,
  input  logic                       out_rtr,
  output logic [$clog2(DEPTH):0]     level,
  output logic [15:0]                issued_cnt,
  output logic [7:0]                 drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [10:0]   SW_LIM   = 11'(SCREEN_W);
  localparam logic [10:0]   SH_LIM   = 11'(SCREEN_H);

  logic [41:0]   mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [15:0]   issued_q, issued_d;
  logic [7:0]    drop_q, drop_d;

  logic empty, full;
  logic in_fire, req_ok, push, drop, pop;
  logic [41:0] op_word;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign empty = (level_q == '0);
  assign full  = (level_q == FULL_LVL);

  // Ready depends only on state (and reset), never on in_rts.
  assign in_rtr  = !rst_ && !full;
  assign out_rts = !empty;
  assign out_op  = empty ? 42'd0 : mem_q[rptr_q];

  assign req_ok  = (in_r != 10'd0) && ({1'b0, in_x} < SW_LIM) && ({1'b0, in_y} < SH_LIM);
  assign in_fire = in_rts && in_rtr;
  assign push    = in_fire && req_ok;
  assign drop    = in_fire && !req_ok;
  assign pop     = out_rts && out_rtr;
  assign op_word = {in_x, in_y, in_r, in_color};

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    level_d  = level_q;
    issued_d = issued_q;
    drop_d   = drop_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop) begin
      rptr_d   = rptr_q + 1'b1;
      issued_d = issued_q + 16'd1;
    end
    // A push and a pop on the same edge leave level unchanged.
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (pop && !push) level_d = level_q - 1'b1;
    if (drop) drop_d = sat_inc8(drop_q);
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      issued_q <= '0;
      drop_q   <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
      issued_q <= issued_d;
      drop_q   <= drop_d;
    end
  end

  // Storage is not reset: out_op is masked to 0 whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= op_word;
  end

  assign level      = level_q;
  assign issued_cnt = issued_q;
  assign drop_cnt   = drop_q;

endmodule
